// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared Q1.15 constants and FSM encoding for the dense stages
package dense_pkg;

    localparam int                 Q15_W   = 16;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } dense_state_e;

endpackage

// File: rtl/q15_max_tree.sv
// rtl/q15_max_tree.sv - combinational signed max of LANES Q1.15 values, lowest index wins ties
module q15_max_tree
    import dense_pkg::*;
#(
    parameter int LANES = 10,
    parameter int IDXW  = 7
) (
    input  logic [LANES*Q15_W-1:0] vals_i,
    input  logic [IDXW-1:0]        base_idx_i,
    output logic signed [15:0]     max_val_o,
    output logic [IDXW-1:0]        max_idx_o
);

    logic signed [15:0] v [LANES];
    logic [IDXW-1:0]    li [LANES];

    // Pairwise reduction: the left (lower-index) operand survives unless the right is strictly larger.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            v[i]  = vals_i[i*Q15_W +: Q15_W];
            li[i] = IDXW'(i);
        end
        for (int step = 1; step < LANES; step = step * 2) begin
            for (int i = 0; i + step < LANES; i = i + 2 * step) begin
                if (v[i+step] > v[i]) begin
                    v[i]  = v[i+step];
                    li[i] = li[i+step];
                end
            end
        end
        max_val_o = v[0];
        max_idx_o = base_idx_i + li[0];
    end

endmodule

// File: rtl/dense_argmax.sv
// rtl/dense_argmax.sv - snapshots dense outputs on completion and reports the argmax class
module dense_argmax
    import dense_pkg::*;
#(
    parameter int n     = 100,
    parameter int LANES = 10,
    parameter int IDXW  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [Q15_W*n-1:0]   y,
    input  logic                 resting,
    output logic                 busy,
    output logic [IDXW-1:0]      class_idx,
    output logic [15:0]          max_val,
    output logic                 valid
);

    localparam int G    = n / LANES;
    localparam int GRPW = (G > 1) ? $clog2(G) : 1;

    dense_state_e          state_q;
    logic                  resting_q;
    logic [Q15_W*n-1:0]    snap_q;
    logic [GRPW-1:0]       grp_q;
    logic signed [15:0]    best_val_q, best_val_d;
    logic [IDXW-1:0]       best_idx_q, best_idx_d;

    logic                  start;
    logic [LANES*Q15_W-1:0] grp_vals;
    logic [IDXW-1:0]       grp_base;
    logic signed [15:0]    grp_max;
    logic [IDXW-1:0]       grp_idx;

    assign start    = resting & ~resting_q;
    assign grp_vals = snap_q[int'(grp_q)*LANES*Q15_W +: LANES*Q15_W];
    assign grp_base = IDXW'(int'(grp_q) * LANES);

    q15_max_tree #(.LANES(LANES), .IDXW(IDXW)) u_tree (
        .vals_i     (grp_vals),
        .base_idx_i (grp_base),
        .max_val_o  (grp_max),
        .max_idx_o  (grp_idx)
    );

    // Strict compare keeps the earlier group's index on equal values.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (grp_max > best_val_q) begin
            best_val_d = grp_max;
            best_idx_d = grp_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            resting_q  <= 1'b0;
            snap_q     <= '0;
            grp_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            class_idx  <= '0;
            max_val    <= '0;
        end else begin
            resting_q <= resting;
            case (state_q)
                ST_IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        snap_q     <= y;
                        grp_q      <= '0;
                        best_val_q <= Q15_MIN;
                        best_idx_q <= '0;
                        busy       <= 1'b1;
                        state_q    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    best_val_q <= best_val_d;
                    best_idx_q <= best_idx_d;
                    grp_q      <= GRPW'(grp_q + 1'b1);
                    if (grp_q == GRPW'(G - 1)) begin
                        class_idx <= best_idx_d;
                        max_val   <= best_val_d;
                        valid     <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_argmax.sv
// tb/tb_dense_argmax.sv - randomized self-checking bench for dense_argmax
module tb_dense_argmax;

    localparam int N    = 100;
    localparam int IDXW = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [16*N-1:0]   y;
    logic              resting;
    logic              busy;
    logic [IDXW-1:0]   class_idx;
    logic [15:0]       max_val;
    logic              valid;

    logic signed [15:0] vec [N];
    int err_cnt = 0;
    int chk_cnt = 0;

    dense_argmax #(.n(N), .LANES(10), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .resting   (resting),
        .busy      (busy),
        .class_idx (class_idx),
        .max_val   (max_val),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_y();
        for (int k = 0; k < N; k++) y[16*k +: 16] = vec[k];
    endtask

    // Reference: first index holding the largest signed value.
    task automatic ref_argmax(output int idx, output logic [15:0] val);
        logic signed [15:0] best;
        best = vec[0];
        idx  = 0;
        for (int k = 1; k < N; k++) begin
            if (vec[k] > best) begin
                best = vec[k];
                idx  = k;
            end
        end
        val = best;
    endtask

    task automatic run_scan(input string tag, input bit snap_ovr, input bit glitch);
        int          exp_idx;
        logic [15:0] exp_val;
        int          first_c = -1;
        int          pulses  = 0;
        int          busy_n  = 0;
        load_y();
        ref_argmax(exp_idx, exp_val);
        resting = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (valid) begin
                pulses++;
                if (first_c < 0) begin
                    first_c = c;
                    check({tag, "_idx"}, 32'(class_idx), 32'(exp_idx));
                    check({tag, "_val"}, 32'(max_val), 32'(exp_val));
                end
            end
            if (snap_ovr && c == 0)
                for (int k = 0; k < N; k++) y[16*k +: 16] = 16'h7FFF;
            if (glitch && c == 3) resting = 1'b0;
            if (glitch && c == 4) resting = 1'b1;
        end
        check({tag, "_latency"}, 32'(first_c), 32'd10);
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd11);
        check({tag, "_hold_idx"}, 32'(class_idx), 32'(exp_idx));
        resting = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          pulses;
        logic [15:0] base;
        rst     = 1'b1;
        resting = 1'b0;
        y       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_idx", 32'(class_idx), 32'd0);
        check("rst_val", 32'(max_val), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < N; k++) vec[k] = 16'(k * 16);
        run_scan("ramp", 1'b0, 1'b0);
        check("ramp_val_const", 32'(max_val), 32'h0630);

        for (int k = 0; k < N; k++) vec[k] = 16'h0100;
        vec[37] = 16'h4000; vec[82] = 16'h4000;
        run_scan("tie_xgrp", 1'b0, 1'b0);
        check("tie_xgrp_const", 32'(class_idx), 32'd37);

        for (int k = 0; k < N; k++) vec[k] = 16'h0100;
        vec[41] = 16'h4000; vec[42] = 16'h4000;
        run_scan("tie_ingrp", 1'b0, 1'b0);
        check("tie_ingrp_const", 32'(class_idx), 32'd41);

        for (int k = 0; k < N; k++) vec[k] = 16'(-1000 - k);
        vec[55] = -16'sd3;
        run_scan("neg", 1'b0, 1'b0);
        check("neg_val_const", 32'(max_val), 32'hFFFD);

        for (int k = 0; k < N; k++) vec[k] = 16'h8000;
        run_scan("all_min", 1'b0, 1'b0);
        check("all_min_const", 32'(max_val), 32'h8000);

        for (int t = 0; t < 6; t++) begin
            base = 16'($urandom);
            for (int k = 0; k < N; k++)
                vec[k] = (t % 2 == 0) ? 16'($urandom) : base + 16'($urandom_range(0, 3));
            run_scan($sformatf("rand%0d", t), 1'b0, 1'b0);
        end

        for (int k = 0; k < N; k++) vec[k] = 16'($urandom_range(0, 16'h7000));
        run_scan("snapshot", 1'b1, 1'b0);

        for (int k = 0; k < N; k++) vec[k] = 16'($urandom);
        run_scan("glitch", 1'b0, 1'b1);
        for (int k = 0; k < N; k++) vec[k] = 16'($urandom);
        run_scan("after_glitch", 1'b0, 1'b0);

        // Reset mid-scan: rst asserted after scan cycle 5, resting dropped with it.
        for (int k = 0; k < N; k++) vec[k] = 16'($urandom);
        load_y();
        resting = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst     = 1'b1;
        resting = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_idx", 32'(class_idx), 32'd0);
        check("mid_rst_val", 32'(max_val), 32'd0);
        rst    = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        check("mid_rst_no_pulse", 32'(pulses), 32'd0);
        for (int k = 0; k < N; k++) vec[k] = 16'($urandom);
        run_scan("post_rst", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
